// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with 1-cycle registered fetch, stall/flush and a
// run-time program-load port. After reset a hardware sweep fills the array with NOP_WORD.
module instr_mem_sync #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h1000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              FETCH_EN,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              PROG_MODE,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_DATA,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              INST_VALID,
  output logic              MEM_READY,
  output logic              PROG_ERR
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {StClear, StReady, StLoad} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]  inst_q, inst_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;

  logic               fetch_in_range;
  logic               prog_in_range;
  logic [DATA_W-1:0]  rd_word;

  // Full-width unsigned compare, so out-of-range addresses never alias into the array.
  assign fetch_in_range = ({1'b0, ADDR} < DEPTH_L);
  assign prog_in_range  = ({1'b0, PROG_ADDR} < DEPTH_L);
  assign rd_word        = fetch_in_range ? mem[ADDR[IDX_W-1:0]] : NOP_WORD;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = PROG_ADDR[IDX_W-1:0];
    mem_wdata = PROG_DATA;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_widx  = clr_cnt_q;
        mem_wdata = NOP_WORD;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        inst_d    = NOP_WORD;
        valid_d   = 1'b0;
        if (clr_cnt_q == LAST_IDX) state_d = StReady;
      end
      StReady: begin
        if (FLUSH) begin
          inst_d  = NOP_WORD;
          valid_d = 1'b0;
        end else if (STALL) begin
          // hold INSTRUCTION and INST_VALID
        end else if (FETCH_EN) begin
          inst_d  = rd_word;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
        if (PROG_MODE) state_d = StLoad;
      end
      StLoad: begin
        inst_d  = NOP_WORD;
        valid_d = 1'b0;
        if (PROG_WE) begin
          if (prog_in_range) mem_we = 1'b1;
          else               err_d  = 1'b1;
        end
        if (!PROG_MODE) state_d = StReady;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      inst_q    <= NOP_WORD;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Array is deliberately not reset; the CLEAR sweep initialises it.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign INSTRUCTION = inst_q;
  assign INST_VALID  = valid_q;
  assign MEM_READY   = (state_q == StReady);
  assign PROG_ERR    = err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: stimulus queues expected outputs tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_instr_mem_sync;

  localparam logic [15:0] NOP = 16'h1000;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  ADDR;
  logic        FETCH_EN, STALL, FLUSH, PROG_MODE, PROG_WE;
  logic [7:0]  PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic [15:0] INSTRUCTION;
  logic        INST_VALID, MEM_READY, PROG_ERR;

  instr_mem_sync #(
    .DATA_W  (16),
    .ADDR_W  (8),
    .DEPTH   (32),
    .NOP_WORD(16'h1000)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ADDR       (ADDR),
    .FETCH_EN   (FETCH_EN),
    .STALL      (STALL),
    .FLUSH      (FLUSH),
    .PROG_MODE  (PROG_MODE),
    .PROG_WE    (PROG_WE),
    .PROG_ADDR  (PROG_ADDR),
    .PROG_DATA  (PROG_DATA),
    .INSTRUCTION(INSTRUCTION),
    .INST_VALID (INST_VALID),
    .MEM_READY  (MEM_READY),
    .PROG_ERR   (PROG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    string       name;
    logic [15:0] inst;
    logic        valid;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due != cyc ||
          {INSTRUCTION, INST_VALID, MEM_READY, PROG_ERR} !== {e.inst, e.valid, e.ready, e.err}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got inst=%h valid=%b ready=%b err=%b, want inst=%h valid=%b ready=%b err=%b",
                 e.name, cyc, INSTRUCTION, INST_VALID, MEM_READY, PROG_ERR,
                 e.inst, e.valid, e.ready, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_at(input string name, input int off, input logic [15:0] inst,
                           input logic valid, input logic ready, input logic err);
    exp_t e;
    e.due = cyc + off; e.name = name; e.inst = inst;
    e.valid = valid; e.ready = ready; e.err = err;
    sb.push_back(e);
  endtask

  // Outcome of the current cycle's inputs, checked after the next edge.
  task automatic step(input string name, input logic [15:0] inst,
                      input logic valid, input logic ready, input logic err);
    expect_at(name, 1, inst, valid, ready, err);
    tick();
  endtask

  initial begin
    RESET_N = 1'b0; ADDR = '0; FETCH_EN = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    PROG_MODE = 1'b0; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;
    tick(); tick();
    expect_at("reset", 0, NOP, 0, 0, 0);

    // Sweep with fetch requested throughout; fetch must be ignored in CLEAR.
    FETCH_EN = 1'b1;
    RESET_N  = 1'b1;
    expect_at("sweep_busy", 31, NOP, 0, 0, 0);
    expect_at("sweep_done", 32, NOP, 0, 1, 0);
    repeat (32) tick();
    for (int i = 0; i < 32; i++) begin
      ADDR = 8'(i);
      step("sweep_nop", NOP, 1, 1, 0);
    end

    // Program load
    FETCH_EN = 1'b0; PROG_MODE = 1'b1;
    step("enter_load", NOP, 0, 0, 0);
    PROG_WE = 1'b1; PROG_ADDR = 8'h00; PROG_DATA = 16'h3102;
    step("load_wr0", NOP, 0, 0, 0);
    PROG_ADDR = 8'h01; PROG_DATA = 16'h3205;
    step("load_wr1", NOP, 0, 0, 0);
    PROG_ADDR = 8'h20; PROG_DATA = 16'hBEEF;
    step("prog_err", NOP, 0, 0, 1);
    PROG_ADDR = 8'h0D; PROG_DATA = 16'h9000; PROG_MODE = 1'b0;
    step("exit_load_wr13", NOP, 0, 1, 0);

    PROG_WE = 1'b0; FETCH_EN = 1'b1;
    ADDR = 8'h00; step("fetch0", 16'h3102, 1, 1, 0);
    ADDR = 8'h01; step("fetch1", 16'h3205, 1, 1, 0);
    ADDR = 8'h0D; step("fetch13", 16'h9000, 1, 1, 0);
    ADDR = 8'h01; step("fetch1b", 16'h3205, 1, 1, 0);

    // Stall holds despite changing ADDR; flush beats stall
    STALL = 1'b1;
    ADDR = 8'h00; step("stall_a", 16'h3205, 1, 1, 0);
    ADDR = 8'h0D; step("stall_b", 16'h3205, 1, 1, 0);
    ADDR = 8'h05; step("stall_c", 16'h3205, 1, 1, 0);
    FLUSH = 1'b1;
    step("flush", NOP, 0, 1, 0);
    STALL = 1'b0; FLUSH = 1'b0;
    ADDR = 8'h0D; step("fetch13b", 16'h9000, 1, 1, 0);
    FETCH_EN = 1'b0;
    step("idle_hold", 16'h9000, 0, 1, 0);

    // Out of range and no aliasing
    FETCH_EN = 1'b1;
    ADDR = 8'h40; step("oor_40", NOP, 1, 1, 0);
    ADDR = 8'h2D; step("oor_2d", NOP, 1, 1, 0);

    // Writes outside LOAD are ignored
    FETCH_EN = 1'b0; PROG_WE = 1'b1; PROG_ADDR = 8'h02; PROG_DATA = 16'hFFFF;
    step("we_ready", NOP, 0, 1, 0);
    PROG_WE = 1'b0; FETCH_EN = 1'b1; ADDR = 8'h02;
    step("old_val2", NOP, 1, 1, 0);

    // Fetch completes on the edge that enters LOAD, then is squashed
    ADDR = 8'h01; PROG_MODE = 1'b1;
    step("fetch_on_load", 16'h3205, 1, 0, 0);
    ADDR = 8'h0D;
    step("load_squash", NOP, 0, 0, 0);
    FETCH_EN = 1'b0; PROG_WE = 1'b1; PROG_ADDR = 8'h00; PROG_DATA = 16'h5555;
    step("load_wr0b", NOP, 0, 0, 0);
    PROG_ADDR = 8'h80;
    step("prog_err2", NOP, 0, 0, 1);

    // Reset mid-LOAD with PROG_MODE held through the new sweep
    @(negedge CLK); #1;
    PROG_WE = 1'b0; RESET_N = 1'b0;
    expect_at("reset_mid_load", 1, NOP, 0, 0, 0);
    tick(); tick();
    RESET_N = 1'b1;
    expect_at("sweep2_busy", 31, NOP, 0, 0, 0);
    expect_at("sweep2_ready", 32, NOP, 0, 1, 0);
    expect_at("mode_held_load", 33, NOP, 0, 0, 0);
    repeat (33) tick();
    PROG_MODE = 1'b0;
    step("exit_load2", NOP, 0, 1, 0);
    FETCH_EN = 1'b1;
    ADDR = 8'h00; step("erased0", NOP, 1, 1, 0);
    ADDR = 8'h01; step("erased1", NOP, 1, 1, 0);
    FETCH_EN = 1'b0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous instruction memory for the 16-bit pipelined processor.
- Replaces the fixed combinational instruction ROM.
- Feeds the IF/ID register with a 1-cycle registered fetch that supports stall and flush.
- Memory is writable at run time through a program-load port. After reset, a hardware sweep fills the whole array with NOP before fetch is allowed.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 8, fetch/program address width.
- DEPTH, 32, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_WORD, 16'h1000, fill/bubble word (ADD R0,R0,R0).

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous active-low reset.
- ADDR  in  ADDR_W  fetch address (PC).
- FETCH_EN  in  1  fetch request this cycle.
- STALL  in  1  hold current INSTRUCTION/INST_VALID.
- FLUSH  in  1  replace next output with NOP_WORD (branch/jump squash).
- PROG_MODE  in  1  request program-load mode.
- PROG_WE  in  1  program write strobe (honoured only in LOAD).
- PROG_ADDR  in  ADDR_W  program write address.
- PROG_DATA  in  DATA_W  program write data.
- INSTRUCTION  out  DATA_W  registered fetched word.
- INST_VALID  out  1  INSTRUCTION holds a real fetch result.
- MEM_READY  out  1  high only in state READY.
- PROG_ERR  out  1  one-cycle pulse: write in LOAD with PROG_ADDR >= DEPTH.

Behaviour:
- Reset (RESET_N=0, asynchronous) sets:
  - state=CLEAR, clear counter=0.
  - INSTRUCTION=NOP_WORD, INST_VALID=0, MEM_READY=0, PROG_ERR=0.
  - The array itself is not asynchronously reset.
- FSM states: CLEAR, READY, LOAD.
- CLEAR:
  - Writes NOP_WORD to address counter each cycle, counter+1.
  - After writing DEPTH-1, goes to READY. Takes exactly DEPTH cycles after reset release.
  - FETCH_EN, PROG_MODE and PROG_WE are ignored.
  - Outputs hold reset values.
- READY:
  - Fetch (FETCH_EN=1, STALL=0, FLUSH=0): next edge INSTRUCTION=mem[ADDR] and INST_VALID=1. Latency is 1 cycle.
  - If ADDR >= DEPTH: INSTRUCTION=NOP_WORD, INST_VALID=1. There is no aliasing.
  - FETCH_EN=0 (no stall/flush): INSTRUCTION holds, INST_VALID=0.
  - STALL=1: INSTRUCTION and INST_VALID hold; ADDR is ignored.
  - FLUSH=1: INSTRUCTION=NOP_WORD, INST_VALID=0. FLUSH has priority over STALL and FETCH_EN.
  - PROG_MODE=1: goes to LOAD next edge. That edge still completes any fetch requested in the same cycle.
- LOAD:
  - MEM_READY=0, INST_VALID=0, INSTRUCTION=NOP_WORD. Fetch is suppressed.
  - PROG_WE=1 and PROG_ADDR < DEPTH: mem[PROG_ADDR]<=PROG_DATA at the edge. One write per cycle, back-to-back allowed.
  - PROG_WE=1 and PROG_ADDR >= DEPTH: no write; PROG_ERR=1 for one cycle.
  - PROG_MODE=0: goes to READY next edge. A PROG_WE in that same cycle is still honoured.
  - First fetch after return reads the updated contents (write-then-read, no bypass needed since fetch is blocked in LOAD).
- PROG_WE outside LOAD: ignored, no PROG_ERR.
- PROG_MODE held high through CLEAR: LOAD is entered on the cycle after the sweep completes (CLEAR->READY->LOAD).
- Reset mid-LOAD or mid-CLEAR: abort immediately; the sweep restarts from address 0 after release. Partially loaded programs are erased.
- Address comparisons are unsigned over the full ADDR_W bits.

Test Plan:
- Reset sweep: release RESET_N with DEPTH=32 -> MEM_READY rises exactly 32 cycles later. Fetch of addr 0..31 returns 16'h1000.
- Load and run: PROG_MODE=1, then write addr0=16'h3102, addr1=16'h3205, addr13=16'h9000; drop PROG_MODE.
  - Fetches of ADDR 0,1,13 return 16'h3102, 16'h3205, 16'h9000, one cycle after request, with INST_VALID=1.
- Stall/flush:
  - Fetch addr1, then STALL=1 for 3 cycles while ADDR changes -> INSTRUCTION stays 16'h3205.
  - Assert FLUSH with STALL=1 -> INSTRUCTION=16'h1000, INST_VALID=0.
- Range:
  - Fetch ADDR=8'h40 -> 16'h1000 with INST_VALID=1.
  - In LOAD, PROG_WE to addr 8'h20 -> PROG_ERR pulses one cycle and addr 0 is unchanged.
- Mode rules:
  - PROG_WE in READY to addr 2 with data 16'hFFFF -> later fetch of addr 2 returns the old value.
  - PROG_MODE held from reset -> LOAD is entered after the sweep.
- Reset mid-LOAD: assert RESET_N=0 during LOAD after writing addr0 -> outputs clear immediately. After the sweep, addr0 reads 16'h1000.
